// File: rtl/bp_gshare.sv
// bp_gshare: one-cycle branch direction predictor built on a table of 2-bit saturating counters.
// Optional feature macro BP_GSHARE_HISTORY_EN: when defined, a speculative global history
// register is XORed into the table index (gshare). When undefined, the table is indexed by PC only (bimodal).
// Redirect and flush pulses are held through a stall and masked while rdy_in is low,
// so a redirect raised just before a stall still reaches fetch once the stall ends.
module bp_gshare #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 7,
    parameter int unsigned HIST_LEN    = 7,
    parameter logic [1:0]  CNT_INIT    = 2'b01
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  decoder_bp_en_in,
    input  logic [ADDR_WIDTH-1:0] decoder_bp_pc_in,
    input  logic [ADDR_WIDTH-1:0] decoder_bp_target_in,
    output logic                  bp_if_en_out,
    output logic [ADDR_WIDTH-1:0] bp_if_pc_out,
    output logic                  bp_instqueue_rst_out,
    output logic                  bp_dispatcher_taken_out,
    output logic [HIST_LEN-1:0]   bp_dispatcher_hist_out,
    input  logic                  rob_bp_en_in,
    input  logic                  rob_bp_taken_in,
    input  logic                  rob_bp_correct_in,
    input  logic [ADDR_WIDTH-1:0] rob_bp_pc_in,
    input  logic [HIST_LEN-1:0]   rob_bp_hist_in
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

    logic [1:0]            cnt_q [DEPTH];
    logic [1:0]            cnt_d [DEPTH];
    logic                  taken_q, taken_d;
    logic                  if_en_q, if_en_d;
    logic                  iq_rst_q, iq_rst_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;

    logic                  mispredict_c;
    logic                  accept_c;
    logic                  pred_taken_c;
    logic [INDEX_WIDTH-1:0] lookup_idx_c;
    logic [INDEX_WIDTH-1:0] update_idx_c;
    logic                  unused_c;

`ifdef BP_GSHARE_HISTORY_EN
    logic [HIST_LEN-1:0]   ghr_q, ghr_d;
    logic [HIST_LEN-1:0]   hist_q, hist_d;
    logic [HIST_LEN:0]     shift_full_c;
    logic [HIST_LEN:0]     restore_full_c;
`endif

    // Table indices, lookup direction and request acceptance
    always_comb begin
        lookup_idx_c = decoder_bp_pc_in[INDEX_WIDTH+1:2];
        update_idx_c = rob_bp_pc_in[INDEX_WIDTH+1:2];
`ifdef BP_GSHARE_HISTORY_EN
        lookup_idx_c = lookup_idx_c ^ INDEX_WIDTH'(ghr_q);
        update_idx_c = update_idx_c ^ INDEX_WIDTH'(rob_bp_hist_in);
`endif
        pred_taken_c = cnt_q[lookup_idx_c][1];
        mispredict_c = rob_bp_en_in & ~rob_bp_correct_in;
        accept_c     = decoder_bp_en_in & ~mispredict_c;
    end

`ifdef BP_GSHARE_HISTORY_EN
    // Candidate history values: speculative shift-in, and restore from the resolved branch
    always_comb begin
        shift_full_c   = {ghr_q, pred_taken_c};
        restore_full_c = {rob_bp_hist_in, rob_bp_taken_in};
    end

    assign unused_c = ^{rob_bp_pc_in, shift_full_c[HIST_LEN], restore_full_c[HIST_LEN]};
`else
    assign unused_c = ^{rob_bp_pc_in, rob_bp_hist_in};
`endif

    // Next-state: prediction outputs, counter training and history maintenance
    always_comb begin
        cnt_d    = cnt_q;
        taken_d  = taken_q;
        if_en_d  = if_en_q;
        iq_rst_d = iq_rst_q;
        if_pc_d  = if_pc_q;
`ifdef BP_GSHARE_HISTORY_EN
        ghr_d    = ghr_q;
        hist_d   = hist_q;
`endif
        if (rdy_in) begin
            if_en_d  = accept_c;
            iq_rst_d = accept_c & pred_taken_c;
            if (accept_c) begin
                taken_d = pred_taken_c;
                if_pc_d = pred_taken_c ? decoder_bp_target_in
                                       : decoder_bp_pc_in + ADDR_WIDTH'(4);
`ifdef BP_GSHARE_HISTORY_EN
                hist_d  = ghr_q;
`endif
            end
            if (rob_bp_en_in) begin
                if (rob_bp_taken_in) begin
                    if (cnt_q[update_idx_c] != 2'b11) begin
                        cnt_d[update_idx_c] = cnt_q[update_idx_c] + 2'd1;
                    end
                end else begin
                    if (cnt_q[update_idx_c] != 2'b00) begin
                        cnt_d[update_idx_c] = cnt_q[update_idx_c] - 2'd1;
                    end
                end
            end
`ifdef BP_GSHARE_HISTORY_EN
            if (mispredict_c) begin
                ghr_d = restore_full_c[HIST_LEN-1:0];
            end else if (accept_c) begin
                ghr_d = shift_full_c[HIST_LEN-1:0];
            end
`endif
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[INDEX_WIDTH'(i)] <= CNT_INIT;
            end
            taken_q  <= 1'b0;
            if_en_q  <= 1'b0;
            iq_rst_q <= 1'b0;
            if_pc_q  <= '0;
`ifdef BP_GSHARE_HISTORY_EN
            ghr_q    <= '0;
            hist_q   <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[INDEX_WIDTH'(i)] <= cnt_d[INDEX_WIDTH'(i)];
            end
            taken_q  <= taken_d;
            if_en_q  <= if_en_d;
            iq_rst_q <= iq_rst_d;
            if_pc_q  <= if_pc_d;
`ifdef BP_GSHARE_HISTORY_EN
            ghr_q    <= ghr_d;
            hist_q   <= hist_d;
`endif
        end
    end

    assign bp_if_en_out            = if_en_q & rdy_in;
    assign bp_instqueue_rst_out    = iq_rst_q & rdy_in;
    assign bp_if_pc_out            = if_pc_q;
    assign bp_dispatcher_taken_out = taken_q;
`ifdef BP_GSHARE_HISTORY_EN
    assign bp_dispatcher_hist_out  = hist_q;
`else
    assign bp_dispatcher_hist_out  = '0;
`endif

endmodule

// File: tb/tb_bp_gshare.sv
// Testbench for bp_gshare: directed scenarios with literal expectations plus a randomized
// run, all outputs compared every cycle against a behavioural predictor model.
// Follows BP_GSHARE_HISTORY_EN the same way the design does.
module tb_bp_gshare;

    localparam int unsigned DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        dec_en;
    logic [31:0] dec_pc;
    logic [31:0] dec_tgt;
    logic        if_en;
    logic [31:0] if_pc;
    logic        iq_rst;
    logic        taken;
    logic [6:0]  hist;
    logic        rob_en;
    logic        rob_taken;
    logic        rob_correct;
    logic [31:0] rob_pc;
    logic [6:0]  rob_hist;

    int n_checks = 0;
    int n_fail   = 0;

    bp_gshare dut (
        .clk_in                  (clk),
        .rst_in                  (rst_n),
        .rdy_in                  (rdy),
        .decoder_bp_en_in        (dec_en),
        .decoder_bp_pc_in        (dec_pc),
        .decoder_bp_target_in    (dec_tgt),
        .bp_if_en_out            (if_en),
        .bp_if_pc_out            (if_pc),
        .bp_instqueue_rst_out    (iq_rst),
        .bp_dispatcher_taken_out (taken),
        .bp_dispatcher_hist_out  (hist),
        .rob_bp_en_in            (rob_en),
        .rob_bp_taken_in         (rob_taken),
        .rob_bp_correct_in       (rob_correct),
        .rob_bp_pc_in            (rob_pc),
        .rob_bp_hist_in          (rob_hist)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt [DEPTH];
    logic [6:0]  m_ghr;
    logic        m_en, m_iq, m_taken;
    logic [31:0] m_pc;
    logic [6:0]  m_hist;
    logic [6:0]  look_hist, upd_hist;
    logic        m_mis, m_acc, m_pred;
    logic [6:0]  m_lidx, m_uidx;

    function automatic logic [6:0] tbl_idx(input logic [31:0] pc, input logic [6:0] h);
        return 7'((pc / 4) % 128) ^ h;
    endfunction

`ifdef BP_GSHARE_HISTORY_EN
    assign look_hist = m_ghr;
    assign upd_hist  = rob_hist;
`else
    assign look_hist = 7'd0;
    assign upd_hist  = 7'd0;
`endif
    assign m_lidx = tbl_idx(dec_pc, look_hist);
    assign m_uidx = tbl_idx(rob_pc, upd_hist);
    assign m_mis  = rob_en && !rob_correct;
    assign m_acc  = dec_en && !m_mis;
    assign m_pred = (m_cnt[m_lidx] >= 2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_cnt[i] <= 1;
            m_ghr <= 7'd0; m_en <= 1'b0; m_iq <= 1'b0;
            m_taken <= 1'b0; m_pc <= 32'd0; m_hist <= 7'd0;
        end else if (rdy) begin
            m_en <= m_acc;
            m_iq <= m_acc && m_pred;
            if (m_acc) begin
                m_taken <= m_pred;
                m_pc    <= m_pred ? dec_tgt : dec_pc + 32'd4;
                m_hist  <= look_hist;
            end
            if (rob_en) begin
                if (rob_taken) m_cnt[m_uidx] <= (m_cnt[m_uidx] >= 3) ? 3 : m_cnt[m_uidx] + 1;
                else           m_cnt[m_uidx] <= (m_cnt[m_uidx] <= 0) ? 0 : m_cnt[m_uidx] - 1;
            end
`ifdef BP_GSHARE_HISTORY_EN
            if (m_mis)      m_ghr <= 7'((int'(rob_hist) * 2 + int'(rob_taken)) % 128);
            else if (m_acc) m_ghr <= 7'((int'(m_ghr) * 2 + int'(m_pred)) % 128);
`endif
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cmp_if_en",  32'(if_en),  32'(m_en & rdy));
        check("cmp_iq_rst", 32'(iq_rst), 32'(m_iq & rdy));
        check("cmp_taken",  32'(taken),  32'(m_taken));
        check("cmp_if_pc",  if_pc,       m_pc);
        check("cmp_hist",   32'(hist),   32'(m_hist));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [31:0] pc, input logic [31:0] tgt);
        dec_en = 1'b1; dec_pc = pc; dec_tgt = tgt;
        step();
        dec_en = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic ok, input logic [6:0] h);
        rob_en = 1'b1; rob_pc = pc; rob_taken = tk; rob_correct = ok; rob_hist = h;
        step();
        rob_en = 1'b0; rob_correct = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 7)) * 4;
    endfunction

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        dec_en = 1'b0; dec_pc = 32'd0; dec_tgt = 32'd0;
        rob_en = 1'b0; rob_taken = 1'b0; rob_correct = 1'b1; rob_pc = 32'd0; rob_hist = 7'd0;

        step(); step();
        check("rst_if_en", 32'(if_en), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_hist",  32'(hist), 32'd0);
        rst_n = 1'b1;

        // first request right after release, untrained entry predicts not-taken
        req(32'h100, 32'h200);
        check("first_taken",  32'(taken),  32'd0);
        check("first_if_pc",  if_pc,       32'h104);
        check("first_if_en",  32'(if_en),  32'd1);
        check("first_iq_rst", 32'(iq_rst), 32'd0);
        check("first_hist",   32'(hist),   32'd0);
        step();
        check("pulse_one_cycle", 32'(if_en), 32'd0);

        // pc+4 wraps
        req(32'hFFFF_FFFC, 32'h40);
        check("wrap_if_pc", if_pc, 32'd0);

        // saturate counter at 3, then predict taken
        repeat (4) upd(32'h100, 1'b1, 1'b1, 7'd0);
        req(32'h100, 32'h200);
        check("sat_taken",  32'(taken),  32'd1);
        check("sat_if_pc",  if_pc,       32'h200);
        check("sat_iq_rst", 32'(iq_rst), 32'd1);
        check("sat_if_en",  32'(if_en),  32'd1);

        // stall with pending request and update
        dec_en = 1'b1; dec_pc = 32'h100; dec_tgt = 32'h300;
        step();
        rdy = 1'b0;
        rob_en = 1'b1; rob_taken = 1'b0; rob_correct = 1'b1; rob_pc = 32'h100; rob_hist = 7'd0;
        #1;
        check("stall_if_en",  32'(if_en),  32'd0);
        check("stall_iq_rst", 32'(iq_rst), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_if_en", 32'(if_en), 32'd0);
        end
        rdy = 1'b1; dec_en = 1'b0; rob_en = 1'b0;
        step(); step();

        // reset mid-stream clears outputs immediately, no pulse after release
        dec_en = 1'b1; dec_pc = 32'h100; dec_tgt = 32'h200;
        step();
        rst_n = 1'b0; dec_en = 1'b0;
        #1;
        check("midrst_if_en", 32'(if_en), 32'd0);
        check("midrst_taken", 32'(taken), 32'd0);
        check("midrst_if_pc", if_pc, 32'd0);
        check("midrst_iq",    32'(iq_rst), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("release_if_en", 32'(if_en), 32'd0);
        step();
        check("post_release_if_en", 32'(if_en), 32'd0);

`ifdef BP_GSHARE_HISTORY_EN
        do_reset();
        upd(32'h100, 1'b1, 1'b1, 7'd0);
        req(32'h100, 32'h200);
        check("gh_t_taken", 32'(taken), 32'd1);
        check("gh_t_hist",  32'(hist),  32'd0);
        req(32'h200, 32'h280);
        check("gh_nt_taken", 32'(taken), 32'd0);
        check("gh_nt_hist",  32'(hist),  32'd1);
        check("gh_nt_pc",    if_pc,      32'h204);
        req(32'h300, 32'h380);
        check("gh_ghr_10", 32'(hist), 32'h2);
        upd(32'h300, 1'b1, 1'b0, 7'h03);
        req(32'h100, 32'h200);
        check("gh_restore", 32'(hist), 32'h7);
        rob_en = 1'b1; rob_taken = 1'b0; rob_correct = 1'b0; rob_hist = 7'h05; rob_pc = 32'h100;
        dec_en = 1'b1; dec_pc = 32'h400; dec_tgt = 32'h500;
        step();
        rob_en = 1'b0; rob_correct = 1'b1; dec_en = 1'b0;
        check("gh_drop_if_en", 32'(if_en), 32'd0);
        check("gh_drop_iq",    32'(iq_rst), 32'd0);
        req(32'h100, 32'h200);
        check("gh_drop_ghr", 32'(hist), 32'h0A);
`else
        do_reset();
        upd(32'h100, 1'b1, 1'b1, 7'h05);
        upd(32'h100, 1'b1, 1'b1, 7'h33);
        req(32'h100, 32'h200);
        check("bm_taken", 32'(taken), 32'd1);
        check("bm_hist",  32'(hist),  32'd0);
        check("bm_pc",    if_pc,      32'h200);
        upd(32'h100, 1'b0, 1'b1, 7'h7F);
        req(32'h100, 32'h200);
        check("bm_still_taken", 32'(taken), 32'd1);
        rob_en = 1'b1; rob_taken = 1'b0; rob_correct = 1'b1; rob_pc = 32'h100; rob_hist = 7'h11;
        dec_en = 1'b1; dec_pc = 32'h100; dec_tgt = 32'h200;
        step();
        rob_en = 1'b0; dec_en = 1'b0;
        check("bm_preupd_taken", 32'(taken), 32'd1);
        check("bm_preupd_en",    32'(if_en), 32'd1);
        req(32'h100, 32'h200);
        check("bm_after_taken", 32'(taken), 32'd0);
        check("bm_after_pc",    if_pc,      32'h104);
        rob_en = 1'b1; rob_taken = 1'b1; rob_correct = 1'b0; rob_pc = 32'h500;
        dec_en = 1'b1; dec_pc = 32'h100;
        step();
        rob_en = 1'b0; rob_correct = 1'b1; dec_en = 1'b0;
        check("bm_drop_if_en", 32'(if_en), 32'd0);
        check("bm_drop_hist",  32'(hist),  32'd0);
`endif

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 255) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            rdy         = ($urandom_range(0, 99) < 85);
            dec_en      = 1'($urandom_range(0, 1));
            dec_pc      = rand_pc();
            dec_tgt     = $urandom;
            rob_en      = ($urandom_range(0, 99) < 40);
            rob_taken   = 1'($urandom_range(0, 1));
            rob_correct = ($urandom_range(0, 99) < 75);
            rob_pc      = rand_pc();
            rob_hist    = 7'($urandom_range(0, 127));
            step();
        end

        rdy = 1'b1; dec_en = 1'b0; rob_en = 1'b0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_gshare.md
BP_GSHARE -- requirements
Module: bp_gshare

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, meaning PC/target width.
REQ-002 The module SHALL have parameter INDEX_WIDTH, default 7, meaning log2 of the pattern-table depth.
REQ-003 The module SHALL have parameter HIST_LEN, default 7, meaning global-history length; legal range 1..INDEX_WIDTH.
REQ-004 The module SHALL have parameter CNT_INIT, default 2'b01, meaning the counter reset value (weakly not-taken).
REQ-005 The module SHALL have these ports:
- clk_in  in  1  clock; the only clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global stall; low freezes all state.
- decoder_bp_en_in  in  1  branch prediction request.
- decoder_bp_pc_in  in  ADDR_WIDTH  branch PC.
- decoder_bp_target_in  in  ADDR_WIDTH  taken target.
- bp_if_en_out  out  1  one-cycle pulse: redirect fetch.
- bp_if_pc_out  out  ADDR_WIDTH  redirect PC.
- bp_instqueue_rst_out  out  1  one-cycle pulse: flush instruction queue.
- bp_dispatcher_taken_out  out  1  predicted direction.
- bp_dispatcher_hist_out  out  HIST_LEN  history snapshot used for this prediction.
- rob_bp_en_in  in  1  branch resolved at commit.
- rob_bp_taken_in  in  1  actual direction.
- rob_bp_correct_in  in  1  prediction was correct.
- rob_bp_pc_in  in  ADDR_WIDTH  resolved branch PC.
- rob_bp_hist_in  in  HIST_LEN  snapshot returned with the branch.

Function
REQ-006 The block SHALL hold 2^INDEX_WIDTH 2-bit saturating counters and one HIST_LEN-bit speculative global history register (GHR).
REQ-007 Index SHALL be pc[INDEX_WIDTH+1:2] XOR zero-extended history: GHR for lookup, rob_bp_hist_in for update.
REQ-008 Prediction SHALL be taken iff the counter value >= 2'b10.
REQ-009 Prediction latency SHALL be one cycle: a request in cycle N drives outputs in cycle N+1.
- bp_dispatcher_taken_out = prediction.
- bp_dispatcher_hist_out = GHR value at cycle N.
REQ-010 bp_if_en_out SHALL pulse for one cycle in both directions.
- bp_if_pc_out = target when taken, pc+4 when not taken; the sum wraps modulo 2^ADDR_WIDTH.
- bp_instqueue_rst_out SHALL pulse only when taken.
REQ-011 On a request, the GHR SHALL shift left one bit, inserting the predicted direction at bit 0.
REQ-012 On rob_bp_en_in, the indexed counter SHALL increment when taken and decrement when not, saturating at 3 and 0.
REQ-013 On rob_bp_en_in with rob_bp_correct_in=0, the GHR SHALL be restored to {rob_bp_hist_in[HIST_LEN-2:0], rob_bp_taken_in}.
- A decoder request in the same cycle SHALL be dropped: no pulse and no GHR shift.
REQ-014 A lookup and an update of the same entry in the same cycle SHALL read the pre-update value.
REQ-015 With rdy_in=0, all state and outputs SHALL hold, and pulse outputs SHALL be forced low.
REQ-016 Back-to-back requests SHALL be accepted every cycle; each uses the GHR already updated by its predecessor.

Reset
REQ-017 While rst_in=0, all counters SHALL be CNT_INIT, GHR 0, all outputs 0, independent of clk_in.
REQ-018 Reset mid-operation SHALL discard any pending prediction, and no pulse SHALL follow release.
REQ-019 The first request SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-020 With macro BP_GSHARE_HISTORY_EN defined, the GHR and XOR indexing SHALL be present.
REQ-021 Without BP_GSHARE_HISTORY_EN, the block SHALL behave as follows:
- Index = pc bits only (bimodal).
- No GHR exists.
- bp_dispatcher_hist_out = 0.
- rob_bp_hist_in is ignored.
- No history restore.

Verification
REQ-022 Reset, then request pc=0x100, target=0x200 -> next cycle: taken=0, if_pc=0x104, if_en=1, instqueue_rst=0, hist=0.
REQ-023 Three ROB taken updates for pc=0x100, hist=0 -> counter saturates at 3; a 4th update leaves it 3.
  - Then a request with GHR=0 -> taken=1, if_pc=0x200, instqueue_rst=1.
REQ-024 Two requests, predicted taken then not-taken, starting from GHR=0 -> GHR=0b10.
  - Then mispredict with hist_in=0b0000011, taken=1 -> GHR=0b0000111.
REQ-025 Same cycle: mispredict plus decoder request -> no if_en pulse, and GHR equals the restored value.
REQ-026 rdy_in=0 for 3 cycles during a request -> outputs frozen, pulses low, counters unchanged.
  - Also assert rst_in=0 mid-stream -> all outputs 0 immediately.
REQ-027 Build without BP_GSHARE_HISTORY_EN; train pc=0x100 taken with varying hist_in -> the same entry updates; hist_out stays 0.
